uart_ev_arbiter: RTL and testbench

//  Shares the single UART event packer between N_SRC timestamper event sources.

---
 rtl/uart_ts_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_ev_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_ev_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_ts_pkg.sv
// Shared definitions for the UART timestamp event path (arbiter and packer).
package uart_ts_pkg;

    localparam int unsigned TS_W = 64;
    localparam int unsigned ID_W = 16;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts_start;
        logic [TS_W-1:0] ts_end;
        logic [TS_W-1:0] delta;
    } ev_t;

    // Round-robin successor of a granted index, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_ev_arbiter.sv
// Round-robin share of the UART event packer between N_SRC timestamper sources,
// with a one-entry output register feeding the packer's ev_* port.
module uart_ev_arbiter
    import uart_ts_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned TS_W  = uart_ts_pkg::TS_W,
    parameter int unsigned ID_W  = uart_ts_pkg::ID_W,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned SW   = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_en,
    input  logic [N_SRC-1:0]        src_mask,
    input  logic [N_SRC-1:0]        in_valid,
    output logic [N_SRC-1:0]        in_ready,
    input  logic [N_SRC*ID_W-1:0]   in_id,
    input  logic [N_SRC*TS_W-1:0]   in_start,
    input  logic [N_SRC*TS_W-1:0]   in_end,
    input  logic [N_SRC*TS_W-1:0]   in_delta,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [ID_W-1:0]         ev_id,
    output logic [TS_W-1:0]         ev_start,
    output logic [TS_W-1:0]         ev_end,
    output logic [TS_W-1:0]         ev_delta,
    output logic [SW-1:0]           ev_src,
    output logic [CNT_W-1:0]        ev_cnt
);

    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] gnt;
    logic [SW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             load;

    logic [ID_W-1:0] sel_id;
    logic [TS_W-1:0] sel_start;
    logic [TS_W-1:0] sel_end;
    logic [TS_W-1:0] sel_delta;

    logic             ev_valid_q, ev_valid_d;
    logic [ID_W-1:0]  ev_id_q,    ev_id_d;
    logic [TS_W-1:0]  ev_start_q, ev_start_d;
    logic [TS_W-1:0]  ev_end_q,   ev_end_d;
    logic [TS_W-1:0]  ev_delta_q, ev_delta_d;
    logic [SW-1:0]    ev_src_q,   ev_src_d;
    logic [CNT_W-1:0] ev_cnt_q,   ev_cnt_d;
    logic [SW-1:0]    rr_ptr_q,   rr_ptr_d;

    assign elig = in_valid & src_mask;

    rr_arbiter #(
        .N  (N_SRC),
        .IW (SW)
    ) u_rr (
        .req (elig),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Slot is free, or the held event leaves this cycle, so a new one can enter.
    assign load     = arb_en & (~ev_valid_q | ev_ready);
    assign in_ready = (rst_n && load) ? gnt : '0;

    // One-hot AND-OR mux of the granted source's fields.
    always_comb begin
        sel_id    = '0;
        sel_start = '0;
        sel_end   = '0;
        sel_delta = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                sel_id    = sel_id    | in_id[i*ID_W +: ID_W];
                sel_start = sel_start | in_start[i*TS_W +: TS_W];
                sel_end   = sel_end   | in_end[i*TS_W +: TS_W];
                sel_delta = sel_delta | in_delta[i*TS_W +: TS_W];
            end
        end
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_id_d    = ev_id_q;
        ev_start_d = ev_start_q;
        ev_end_d   = ev_end_q;
        ev_delta_d = ev_delta_q;
        ev_src_d   = ev_src_q;
        ev_cnt_d   = ev_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (load && gnt_any) begin
            ev_valid_d = 1'b1;
            ev_id_d    = sel_id;
            ev_start_d = sel_start;
            ev_end_d   = sel_end;
            ev_delta_d = sel_delta;
            ev_src_d   = gnt_idx;
            ev_cnt_d   = ev_cnt_q + 1'b1;
            rr_ptr_d   = SW'(rr_next(32'(gnt_idx), N_SRC));
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ev_start_q <= '0;
            ev_end_q   <= '0;
            ev_delta_q <= '0;
            ev_src_q   <= '0;
            ev_cnt_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            ev_start_q <= ev_start_d;
            ev_end_q   <= ev_end_d;
            ev_delta_q <= ev_delta_d;
            ev_src_q   <= ev_src_d;
            ev_cnt_q   <= ev_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_id    = ev_id_q;
    assign ev_start = ev_start_q;
    assign ev_end   = ev_end_q;
    assign ev_delta = ev_delta_q;
    assign ev_src   = ev_src_q;
    assign ev_cnt   = ev_cnt_q;

endmodule

// File: tb/tb_uart_ev_arbiter.sv
// Bench for uart_ev_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_uart_ev_arbiter;
    import uart_ts_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arb_en;
    logic [N-1:0]  src_mask;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [N*16-1:0] in_id;
    logic [N*64-1:0] in_start, in_end, in_delta;
    logic          ev_valid, ev_ready;
    logic [15:0]   ev_id;
    logic [63:0]   ev_start, ev_end, ev_delta;
    logic [1:0]    ev_src;
    logic [31:0]   ev_cnt;

    always #5 clk = ~clk;

    uart_ev_arbiter #(.N_SRC(N), .TS_W(64), .ID_W(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .src_mask(src_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_start(in_start), .in_end(in_end), .in_delta(in_delta),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id),
        .ev_start(ev_start), .ev_end(ev_end), .ev_delta(ev_delta),
        .ev_src(ev_src), .ev_cnt(ev_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Source side: pending event per source, plus what happens after a handshake
    // (0: go idle, 1: offer a fresh event, 2: random including idle sources waking up).
    ev_t         src_ev[N];
    logic [N-1:0] s_valid;
    int          refill;

    // Reference model of the held output and arbitration state.
    logic        m_v;
    ev_t         m_ev;
    int          m_src;
    logic [31:0] m_cnt;
    int          m_ptr;
    logic [N-1:0] exp_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t rand_ev();
        ev_t e;
        e.id       = 16'($urandom);
        e.ts_start = {$urandom, $urandom};
        e.ts_end   = {$urandom, $urandom};
        e.delta    = {$urandom, $urandom};
        return e;
    endfunction

    // First eligible source counting upward from ptr, wrapping around.
    function automatic int pick(input logic [N-1:0] el, input int ptr);
        for (int k = 0; k < N; k++)
            if (el[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic pack();
        in_valid = s_valid;
        for (int i = 0; i < N; i++) begin
            in_id[i*16 +: 16]    = src_ev[i].id;
            in_start[i*64 +: 64] = src_ev[i].ts_start;
            in_end[i*64 +: 64]   = src_ev[i].ts_end;
            in_delta[i*64 +: 64] = src_ev[i].delta;
        end
    endtask

    task automatic model_reset();
        m_v = 1'b0; m_ev = '0; m_src = 0; m_cnt = '0; m_ptr = 0;
    endtask

    // One clock: check combinational ready, advance model at the edge, check registers.
    task automatic cycle();
        int   g;
        logic ld;
        pack();
        #1;
        ld = arb_en && (!m_v || ev_ready);
        g  = pick(s_valid & src_mask, m_ptr);
        exp_rdy = (rst_n && ld && g >= 0) ? N'(1 << g) : '0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (ld && g >= 0) begin
            m_v = 1'b1; m_ev = src_ev[g]; m_src = g; m_cnt = m_cnt + 1;
            m_ptr = (g + 1) % N;
        end else if (m_v && ev_ready) m_v = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                src_ev[i] = rand_ev();
                s_valid[i] = (refill == 1) ? 1'b1 : (refill == 2) ? 1'($urandom) : 1'b0;
            end else if (refill == 2 && !s_valid[i]) begin
                s_valid[i] = ($urandom_range(0, 3) == 0);
                if (s_valid[i]) src_ev[i] = rand_ev();
            end
        end
        chk("ev_valid", 64'(ev_valid), 64'(m_v));
        chk("ev_cnt", 64'(ev_cnt), 64'(m_cnt));
        if (m_v) begin
            chk("ev_id", 64'(ev_id), 64'(m_ev.id));
            chk("ev_start", ev_start, m_ev.ts_start);
            chk("ev_end", ev_end, m_ev.ts_end);
            chk("ev_delta", ev_delta, m_ev.delta);
            chk("ev_src", 64'(ev_src), 64'(m_src));
        end
    endtask

    initial begin
        rst_n = 1'b0; arb_en = 1'b1; src_mask = '1; ev_ready = 1'b1;
        s_valid = '0; refill = 0;
        for (int i = 0; i < N; i++) src_ev[i] = rand_ev();
        model_reset();
        @(posedge clk); #1;
        cycle(); cycle();
        chk("rst_valid", 64'(ev_valid), 64'd0);
        chk("rst_id", 64'(ev_id), 64'd0);
        chk("rst_start", ev_start, 64'd0);
        chk("rst_src", 64'(ev_src), 64'd0);
        chk("rst_cnt", 64'(ev_cnt), 64'd0);
        rst_n = 1'b1;

        // Single source.
        s_valid = 4'b0100;
        cycle();
        chk("single_rdy", 64'(exp_rdy), 64'h4);
        chk("single_src", 64'(ev_src), 64'd2);
        chk("single_cnt", 64'(ev_cnt), 64'd1);
        cycle();

        // Fairness from a fresh pointer.
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        refill = 1; s_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("fair_src", 64'(ev_src), 64'(k % N));
        end
        chk("fair_cnt", 64'(ev_cnt), 64'd8);

        // Backpressure, then release with no bubble.
        ev_ready = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        ev_ready = 1'b1;
        cycle(); cycle();

        // Mask out source 1.
        src_mask = 4'b1101;
        for (int k = 0; k < 10; k++) cycle();
        chk("mask_held", 64'(in_valid[1]), 64'd1);
        src_mask = '1;

        // Disable: held event drains, nothing new.
        arb_en = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("dis_drained", 64'(ev_valid), 64'd0);
        arb_en = 1'b1;

        // Pointer wrap: land on 3, then 3 -> 0.
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        refill = 0; s_valid = 4'b0100;
        cycle();
        s_valid = 4'b1001;
        cycle();
        chk("wrap_3", 64'(ev_src), 64'd3);
        cycle();
        chk("wrap_0", 64'(ev_src), 64'd0);
        s_valid = 4'b0011;
        cycle();
        chk("wrap_1", 64'(ev_src), 64'd1);

        // Reset while holding under backpressure.
        refill = 1; s_valid = '1; ev_ready = 1'b0;
        cycle(); cycle();
        rst_n = 1'b0;
        cycle();
        chk("midrst_valid", 64'(ev_valid), 64'd0);
        chk("midrst_cnt", 64'(ev_cnt), 64'd0);
        cycle();
        rst_n = 1'b1; ev_ready = 1'b1;
        cycle();
        chk("midrst_ptr0", 64'(ev_src), 64'd0);

        // Random traffic.
        refill = 2;
        for (int k = 0; k < 400; k++) begin
            ev_ready = ($urandom_range(0, 3) != 0);
            arb_en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) src_mask = 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
